// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD conversion arbiter.
// Build option: BCD_ARB_RR_EN selects round-robin arbitration.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_e;

    localparam int          BCD_DW      = 4;
    localparam int unsigned BCD_MAX_DEC = 999999;
    localparam logic [23:0] BCD_SAT     = 24'h999999;

    function automatic logic [BCD_DW-1:0] add3(input logic [BCD_DW-1:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_shift_engine.sv
// Iterative add-3-and-shift converter, one input bit per cycle.
// done is high during the cycle whose closing edge performs the last shift.
module bcd_shift_engine
    import bcd_pkg::*;
#(
    parameter int N = 20,
    parameter int D = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [N-1:0]        data,
    output logic [BCD_DW*D-1:0] bcd,
    output logic                done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

    logic [N-1:0]        shreg_q, shreg_d;
    logic [BCD_DW*D-1:0] dig_q, dig_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [BCD_DW*D-1:0] adj;

    always_comb begin
        adj = '0;
        for (int i = 0; i < D; i++) begin
            adj[i*BCD_DW +: BCD_DW] = add3(dig_q[i*BCD_DW +: BCD_DW]);
        end
    end

    assign done = busy_q && (cnt_q == '0);
    assign bcd  = dig_q;

    always_comb begin
        shreg_d = shreg_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (load) begin
            shreg_d = data;
            dig_d   = '0;
            cnt_d   = CNT_INIT;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            // Adjusted digits and the shift register move as one wide word.
            dig_d   = {adj[BCD_DW*D-2:0], shreg_q[N-1]};
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - CW'(1);
            busy_d  = (cnt_q != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Arbitrated front end sharing one binary-to-BCD engine among requesters.
// Build option: BCD_ARB_RR_EN selects round-robin, else fixed lowest-index priority.
module bcd_conv_arbiter
    import bcd_pkg::*;
#(
    parameter  int N_REQ = 2,
    parameter  int N     = 20,
    parameter  int D     = 6,
    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*N-1:0]  req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [4*D-1:0]      rsp_bcd,
    output logic                rsp_ovf
);

    localparam logic [4*D-1:0] SAT = (4*D)'(BCD_SAT);

    bcd_state_e     state_q;
    logic [IDW-1:0] id_q;
    logic           ovf_q;
    logic           rsp_valid_q;

    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gidx;
    logic             found;
    logic [N-1:0]     sel_data;
    logic             accept;
    logic             eng_done;
    logic [4*D-1:0]   eng_bcd;

`ifdef BCD_ARB_RR_EN
    logic [IDW-1:0] ptr_q;

    always_comb begin
        int j;
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req_valid[j]) begin
                found  = 1'b1;
                gidx   = IDW'(j);
                gnt[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= (int'(gidx) == N_REQ - 1) ? '0 : gidx + IDW'(1);
        end
    end
`else
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[k]) begin
                found  = 1'b1;
                gidx   = IDW'(k);
                gnt[k] = 1'b1;
            end
        end
    end
`endif

    assign req_ready = (rst_n && state_q == IDLE) ? gnt : '0;
    assign accept    = |(req_valid & req_ready);
    assign sel_data  = req_data[int'(gidx)*N +: N];

    bcd_shift_engine #(
        .N (N),
        .D (D)
    ) u_engine (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .data  (sel_data),
        .bcd   (eng_bcd),
        .done  (eng_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id_q        <= '0;
            ovf_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= SHIFT;
                        id_q    <= gidx;
                        ovf_q   <= (32'(sel_data) > BCD_MAX_DEC);
                    end
                end
                SHIFT: begin
                    if (eng_done) begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Engine digits are only meaningful once the conversion has finished.
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_ovf   = ovf_q;
    assign rsp_bcd   = !rsp_valid_q ? '0 : (ovf_q ? SAT : eng_bcd);

endmodule
